mac_param_acc: RTL and testbench
================================

// Module: mac_param_acc
// PURPOSE
//  Parametrised signed multiply-accumulate engine; next generation of the 4-bit/8-term MAC.
//  Pairs independently-valid operands A and B, accumulates ACC_LEN products, emits one result.
//  Adds generic widths, valid/ready backpressure on all ports, sync block clear, optional saturation.
//  Sits between operand producers and a result consumer in the datapath; single clock domain.
// PARAMETERS
//  DATA_W   4    signed operand width
//  ACC_LEN  8    products per result, >=2
//  ACC_W    2*DATA_W+$clog2(ACC_LEN)  accumulator/result width (11 at defaults)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  reset       in   1       asynchronous, active-high reset
//  in_a        in   DATA_W  signed operand A
//  in_valid_a  in   1       A valid
//  in_ready_a  out  1       A slot can accept
//  in_b        in   DATA_W  signed operand B
//  in_valid_b  in   1       B valid
//  in_ready_b  out  1       B slot can accept
//  acc_clr     in   1       sync clear: drop partial block and operand slots
//  mac_out     out  ACC_W   signed result
//  out_valid   out  1       result valid
//  out_ready   in   1       consumer accepts result
//  term_cnt    out  $clog2(ACC_LEN+1)  products accumulated in current block
//  out_ovf     out  1       result saturated (MAC_SAT_EN only, else 0)
// BEHAVIOUR
//  Reset: slots empty, acc=0, term_cnt=0, mac_out=0, out_valid=0, out_ovf=0, state IDLE.
//  Operand slots: one entry each. in_ready_x = !full_x | fire. Accept on in_valid_x & in_ready_x.
//  State = {full_a,full_b}: IDLE(00), WAIT_B(10), WAIT_A(01), MAC(11).
//   IDLE->MAC both accepted; ->WAIT_B only A; ->WAIT_A only B; MAC->MAC on fire + both reloaded.
//  fire = full_a & full_b & !stall; stall = (term_cnt==ACC_LEN-1) & out_valid & !out_ready.
//  On fire: product = a*b (2*DATA_W signed, sign-extended to ACC_W); acc += product; term_cnt++.
//  ACC_LEN-th fire: mac_out <= acc+product, out_valid<=1 next edge, acc<=0, term_cnt<=0.
//  Latency: final pair in slots -> out_valid 1 cycle. Back-to-back blocks: no bubble.
//  out_valid held with mac_out stable until out_valid & out_ready; partial block proceeds meanwhile.
//  Same-cycle result handoff and new completion: allowed; new result loads, out_valid stays 1.
//  Non-final fires never stall. Operands arriving while slot full and not firing: in_ready low.
//  acc_clr: slots emptied, acc/term_cnt=0 next edge; pending mac_out/out_valid untouched;
//   acc_clr wins over simultaneous accepts/fire.
//  reset mid-block: all state to reset values immediately; pending result discarded.
//  Without MAC_SAT_EN: acc arithmetic wraps modulo 2^ACC_W.
// CONFIGURATION
//  MAC_SAT_EN defined: each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
//   out_ovf=1 with result if any clamp in that block; sticky per block, cleared by reset/acc_clr.
//  MAC_SAT_EN undefined: wrap arithmetic, out_ovf constant 0, no clamp logic synthesised.
// TESTING (defaults unless noted; out_ready=1 unless noted)
//  8 pairs a=-8,b=-8, both valid every cycle -> mac_out=512, out_valid 1 cycle after 8th pair.
//  8 pairs a=7,b=-8 -> mac_out=-448; next block 8x(1,1) back-to-back -> 8, no gap cycle.
//  A=3 valid 3 cycles before B=5 -> in_ready_a low 2 cycles, fire once B lands, term_cnt=1.
//  out_ready=0 on result 1, run next 8 pairs -> 7 fire, 8th stalls, mac_out holds result 1.
//  reset pulse after 5 pairs (mid-cycle) -> outputs zero at once; next 8x(2,3) -> 48.
//  MAC_SAT_EN, ACC_W=8: 8x(-8,-8) -> mac_out=127, out_ovf=1; without macro -> 0 (512 mod 256).

Source files
------------

// File: rtl/mac_param_acc.sv
// Signed multiply-accumulate engine: pairs operands A and B, sums ACC_LEN products and emits one result.
// Optional saturating arithmetic is enabled by defining MAC_SAT_EN; default build wraps modulo 2^ACC_W.
module mac_param_acc #(
  parameter int DATA_W  = 4,
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 2 * DATA_W + $clog2(ACC_LEN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              in_a,
  input  logic                           in_valid_a,
  output logic                           in_ready_a,
  input  logic [DATA_W-1:0]              in_b,
  input  logic                           in_valid_b,
  output logic                           in_ready_b,
  input  logic                           acc_clr,
  output logic [ACC_W-1:0]               mac_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(ACC_LEN+1)-1:0]   term_cnt,
  output logic                           out_ovf,
  output logic [1:0]                     dbg_state
);

  localparam int CW = $clog2(ACC_LEN + 1);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST_TERM = CW'(ACC_LEN - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid must not depend on ready, and the payload is held stable while valid waits for ready.

  // State encodes slot occupancy as {full_a, full_b}.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_A = 2'b01,
    WAIT_B = 2'b10,
    MAC    = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0]  mac_out_q, mac_out_d;
  logic              out_valid_q, out_valid_d;

  logic              full_a, full_b;
  logic              full_a_d, full_b_d;
  logic              last_term, stall, fire, do_mac, done;
  logic              accept_a, accept_b;
  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  acc_new;

  assign full_a    = state_q[1];
  assign full_b    = state_q[0];
  assign last_term = (term_cnt_q == LAST_TERM);
  // Only a completing product can be blocked, and only by an unconsumed previous result.
  assign stall     = last_term & out_valid_q & ~out_ready;
  assign fire      = full_a & full_b & ~stall;
  assign do_mac    = fire & ~acc_clr;
  assign done      = do_mac & last_term;

  assign in_ready_a = ~full_a | fire;
  assign in_ready_b = ~full_b | fire;
  assign accept_a   = in_valid_a & in_ready_a;
  assign accept_b   = in_valid_b & in_ready_b;

  assign prod = PW'($signed(a_q)) * PW'($signed(b_q));

  always_comb begin
    full_a_d = full_a;
    full_b_d = full_b;
    if (fire) begin
      full_a_d = 1'b0;
      full_b_d = 1'b0;
    end
    if (accept_a) full_a_d = 1'b1;
    if (accept_b) full_b_d = 1'b1;
    if (acc_clr) begin
      full_a_d = 1'b0;
      full_b_d = 1'b0;
    end
    state_d = state_t'({full_a_d, full_b_d});
  end

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_ext;
  logic           clamp;
  logic           ovf_q, ovf_d;
  logic           out_ovf_q, out_ovf_d;

  // One guard bit exposes signed overflow of the accumulate step.
  always_comb begin
    sum_ext = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'($signed(prod));
    clamp   = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_new = sum_ext[ACC_W-1:0];
    if (clamp) acc_new = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf_q;
    if (acc_clr) begin
      ovf_d = 1'b0;
    end else if (done) begin
      ovf_d     = 1'b0;
      out_ovf_d = ovf_q | clamp;
    end else if (do_mac) begin
      ovf_d = ovf_q | clamp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  assign acc_new = acc_q + ACC_W'($signed(prod));
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    mac_out_d   = mac_out_q;
    out_valid_d = out_valid_q;
    if (accept_a & ~acc_clr) a_d = in_a;
    if (accept_b & ~acc_clr) b_d = in_b;
    if (out_valid_q & out_ready) out_valid_d = 1'b0;
    // A new completion in the same cycle as a handoff keeps out_valid high.
    if (acc_clr) begin
      acc_d      = '0;
      term_cnt_d = '0;
    end else if (done) begin
      acc_d       = '0;
      term_cnt_d  = '0;
      mac_out_d   = acc_new;
      out_valid_d = 1'b1;
    end else if (do_mac) begin
      acc_d      = acc_new;
      term_cnt_d = term_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      term_cnt_q  <= '0;
      mac_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      mac_out_q   <= mac_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mac_out   = mac_out_q;
  assign out_valid = out_valid_q;
  assign term_cnt  = term_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_param_acc.sv
// Bench for mac_param_acc: directed scenarios plus random traffic checked against a block-sum model.
// A second instance with ACC_W=8 exercises wrap versus MAC_SAT_EN saturation.
module tb_mac_param_acc;

  localparam int DW  = 4;
  localparam int AL  = 8;
  localparam int AW  = 11;
  localparam int AW8 = 8;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  in_a, in_b;
  logic           in_valid_a, in_valid_b;
  logic           in_ready_a, in_ready_b;
  logic           acc_clr;
  logic [AW-1:0]  mac_out;
  logic           out_valid, out_ready;
  logic [CW-1:0]  term_cnt;
  logic           out_ovf;
  logic [1:0]     dbg_state;

  logic           in_ready_a8, in_ready_b8;
  logic [AW8-1:0] mac_out8;
  logic           out_valid8;
  logic [CW-1:0]  term_cnt8;
  logic           out_ovf8;
  logic [1:0]     dbg_state8;

  mac_param_acc #(.DATA_W(DW), .ACC_LEN(AL), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b),
    .acc_clr(acc_clr), .mac_out(mac_out), .out_valid(out_valid), .out_ready(out_ready),
    .term_cnt(term_cnt), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  mac_param_acc #(.DATA_W(DW), .ACC_LEN(AL), .ACC_W(AW8)) dut8 (
    .clk(clk), .reset(reset),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a8),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b8),
    .acc_clr(acc_clr), .mac_out(mac_out8), .out_valid(out_valid8), .out_ready(out_ready),
    .term_cnt(term_cnt8), .out_ovf(out_ovf8), .dbg_state(dbg_state8)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: accepted operands in order, block sums of ACC_LEN products
  int            mdl_a[$];
  int            mdl_b[$];
  int            part = 0;
  int            pcnt = 0;
  logic [AW-1:0] exp_q[$];
  logic          rdy_a_s, rdy_b_s;

  function automatic logic [31:0] m11(input int v);
    logic [AW-1:0] t;
    t = AW'(v);
    return 32'(t);
  endfunction

  function automatic logic [31:0] m8(input int v);
    logic [AW8-1:0] t;
    t = AW8'(v);
    return 32'(t);
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_pair();
    while (mdl_a.size() > 0 && mdl_b.size() > 0) begin
      part = part + mdl_a.pop_front() * mdl_b.pop_front();
      pcnt++;
      if (pcnt == AL) begin
        exp_q.push_back(AW'(part));
        part = 0;
        pcnt = 0;
      end
    end
  endtask

  task automatic model_flush(input bit drop_results);
    mdl_a.delete();
    mdl_b.delete();
    part = 0;
    pcnt = 0;
    if (drop_results) exp_q.delete();
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic cyc(input bit va, input int a, input bit vb, input int b);
    in_valid_a = va;
    in_a       = DW'(a);
    in_valid_b = vb;
    in_b       = DW'(b);
    @(negedge clk);
    rdy_a_s = in_ready_a;
    rdy_b_s = in_ready_b;
    if (acc_clr) begin
      model_flush(1'b0);
    end else begin
      if (va && in_ready_a) mdl_a.push_back(a);
      if (vb && in_ready_b) mdl_b.push_back(b);
      model_pair();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0, 0);
  endtask

  // scoreboard: every result handshake must match the next expected block sum
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed result %0h expected none", mac_out);
      end
      if (exp_q.size() != 0) chk("sb_result", 32'(mac_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [AW-1:0] e1, e2;
    bit            all_rdy;
    int            ra, rb;
    e1 = '0;
    e2 = '0;
    reset      = 1'b1;
    in_a       = '0;
    in_b       = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    acc_clr    = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mac_out", 32'(mac_out), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_term_cnt", 32'(term_cnt), 32'(0));
    chk("rst_out_ovf", 32'(out_ovf), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));
    reset = 1'b0;
    idle(1);
    chk("idle_ready_a", 32'(in_ready_a), 32'(1));
    chk("idle_ready_b", 32'(in_ready_b), 32'(1));

    // 8 x (-8,-8): 512, and the 8-bit instance wraps or saturates
    for (int i = 0; i < AL; i++) cyc(1'b1, -8, 1'b1, -8);
    chk("neg_pre_valid", 32'(out_valid), 32'(0));
    chk("neg_pre_term", 32'(term_cnt), 32'(7));
    idle(1);
    chk("neg_valid", 32'(out_valid), 32'(1));
    chk("neg_mac_out", 32'(mac_out), m11(512));
    chk("neg_term", 32'(term_cnt), 32'(0));
    chk("neg_ovf", 32'(out_ovf), 32'(0));
    chk("w8_valid", 32'(out_valid8), 32'(1));
    chk("w8_term", 32'(term_cnt8), 32'(0));
    chk("w8_ready", 32'({in_ready_a8, in_ready_b8}), 32'(2'b11));
    chk("w8_state", 32'(dbg_state8), 32'(0));
`ifdef MAC_SAT_EN
    chk("w8_mac_out", 32'(mac_out8), m8(127));
    chk("w8_ovf", 32'(out_ovf8), 32'(1));
`else
    chk("w8_mac_out", 32'(mac_out8), m8(0));
    chk("w8_ovf", 32'(out_ovf8), 32'(0));
`endif
    idle(2);

    // 8 x (7,-8) then 8 x (1,1) back-to-back
    all_rdy = 1'b1;
    for (int i = 0; i < 2 * AL; i++) begin
      if (i < AL) cyc(1'b1, 7, 1'b1, -8);
      else        cyc(1'b1, 1, 1'b1, 1);
      all_rdy = all_rdy & rdy_a_s & rdy_b_s;
      if (i == AL) begin
        chk("b2b_first_valid", 32'(out_valid), 32'(1));
        chk("b2b_first_out", 32'(mac_out), m11(-448));
      end
    end
    chk("b2b_no_bubble", 32'(all_rdy), 32'(1));
    chk("b2b_term", 32'(term_cnt), 32'(7));
    idle(1);
    chk("b2b_second_valid", 32'(out_valid), 32'(1));
    chk("b2b_second_out", 32'(mac_out), m11(8));
    idle(2);

    // A=3 three cycles ahead of B=5
    cyc(1'b1, 3, 1'b0, 0);
    chk("skew_state_wb", 32'(dbg_state), 32'(2'b10));
    cyc(1'b1, 3, 1'b0, 0);
    chk("skew_ready_a_1", 32'(rdy_a_s), 32'(0));
    cyc(1'b1, 3, 1'b0, 0);
    chk("skew_ready_a_2", 32'(rdy_a_s), 32'(0));
    chk("skew_no_fire", 32'(term_cnt), 32'(0));
    cyc(1'b0, 0, 1'b1, 5);
    chk("skew_ready_b", 32'(rdy_b_s), 32'(1));
    chk("skew_state_mac", 32'(dbg_state), 32'(2'b11));
    idle(1);
    chk("skew_term", 32'(term_cnt), 32'(1));
    chk("skew_state_idle", 32'(dbg_state), 32'(0));

    // result 1 held with out_ready low; next block fires 7 and stalls on the 8th
    out_ready = 1'b0;
    for (int i = 0; i < 2 * AL - 1; i++) cyc(1'b1, rnd_op(), 1'b1, rnd_op());
    idle(2);
    chk("stall_accepted", 32'(exp_q.size()), 32'(2));
    if (exp_q.size() >= 2) begin
      e1 = exp_q[0];
      e2 = exp_q[1];
    end
    chk("stall_term", 32'(term_cnt), 32'(7));
    chk("stall_valid", 32'(out_valid), 32'(1));
    chk("stall_hold", 32'(mac_out), 32'(e1));
    chk("stall_ready_a", 32'(in_ready_a), 32'(0));
    chk("stall_state", 32'(dbg_state), 32'(2'b11));
    out_ready = 1'b1;
    idle(1);
    chk("handoff_valid", 32'(out_valid), 32'(1));
    chk("handoff_out", 32'(mac_out), 32'(e2));
    chk("handoff_term", 32'(term_cnt), 32'(0));
    idle(2);

    // reset mid-block with a result pending
    out_ready = 1'b0;
    for (int i = 0; i < AL + 5; i++) cyc(1'b1, rnd_op(), 1'b1, rnd_op());
    chk("mid_term", 32'(term_cnt), 32'(4));
    chk("mid_pending", 32'(out_valid), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out", 32'(mac_out), 32'(0));
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_term", 32'(term_cnt), 32'(0));
    chk("mid_rst_state", 32'(dbg_state), 32'(0));
    model_flush(1'b1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < AL; i++) cyc(1'b1, 2, 1'b1, 3);
    idle(1);
    chk("post_rst_valid", 32'(out_valid), 32'(1));
    chk("post_rst_out", 32'(mac_out), m11(48));
    idle(2);

    // acc_clr with a partial block, a half-loaded slot and a pending result
    out_ready = 1'b0;
    for (int i = 0; i < AL; i++) cyc(1'b1, rnd_op(), 1'b1, rnd_op());
    if (exp_q.size() >= 1) e1 = exp_q[0];
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_op(), 1'b1, rnd_op());
    idle(1);
    chk("clr_pre_term", 32'(term_cnt), 32'(3));
    ra = rnd_op();
    cyc(1'b1, ra, 1'b0, 0);
    chk("clr_pre_state", 32'(dbg_state), 32'(2'b10));
    acc_clr = 1'b1;
    rb = rnd_op();
    cyc(1'b0, 0, 1'b1, rb);
    acc_clr = 1'b0;
    chk("clr_term", 32'(term_cnt), 32'(0));
    chk("clr_state", 32'(dbg_state), 32'(0));
    chk("clr_keep_valid", 32'(out_valid), 32'(1));
    chk("clr_keep_out", 32'(mac_out), 32'(e1));
    out_ready = 1'b1;
    for (int i = 0; i < AL; i++) cyc(1'b1, rnd_op(), 1'b1, rnd_op());
    idle(3);
    chk("clr_after_term", 32'(term_cnt), 32'(0));

    // random traffic with independent valids and random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 1)), rnd_op(), 1'($urandom_range(0, 1)), rnd_op());
    end
    out_ready = 1'b1;
    idle(20);
    chk("rand_drained", 32'(exp_q.size()), 32'(0));
    chk("rand_term", 32'(term_cnt), 32'(pcnt));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
